wm_program_controller: RTL and testbench

//  Programmable washing-machine sequencer: door lock -> fill -> detergent -> wash -> drain ->
//  N x (fill -> rinse -> drain) -> spin -> done. Internal tick-driven phase timers replace

---
 rtl/wm_pkg.sv | 32 +++
 rtl/wm_phase_timer.sv | 32 +++
 rtl/wm_program_controller.sv | 258 +++++++++++++++++++++++++
 tb/tb_wm_program_controller.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - shared state, fault-code and wash-mode definitions for the washer sequencer
package wm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_FILL        = 4'd1,
    ST_SOAP        = 4'd2,
    ST_WASH        = 4'd3,
    ST_DRAIN       = 4'd4,
    ST_SPIN        = 4'd5,
    ST_DONE        = 4'd6,
    ST_ABORT_DRAIN = 4'd7,
    ST_FAULT       = 4'd8
  } wm_state_e;

  localparam logic [1:0] FC_NONE      = 2'd0;
  localparam logic [1:0] FC_FILL_TMO  = 2'd1;
  localparam logic [1:0] FC_DRAIN_TMO = 2'd2;
  localparam logic [1:0] FC_DOOR      = 2'd3;

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_QUICK  = 2'd1;
  localparam logic [1:0] MODE_HEAVY  = 2'd2;
  localparam logic [1:0] MODE_RINSE  = 2'd3;

  // Running phases: the ones that honour pause and fall back to ABORT_DRAIN on cancel.
  function automatic logic is_active(wm_state_e s);
    return (s == ST_FILL) || (s == ST_SOAP) || (s == ST_WASH) ||
           (s == ST_DRAIN) || (s == ST_SPIN);
  endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// rtl/wm_phase_timer.sv - loadable tick-driven down counter with hold and zero flag
module wm_phase_timer
  import wm_pkg::*;
#(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  input  logic               tick,
  input  logic               hold,
  output logic [TIMER_W-1:0] value,
  output logic               zero
);

  localparam logic [TIMER_W-1:0] ONE = TIMER_W'(1);

  // Load wins over counting; counting stops at zero and while held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (tick && !hold && (value != '0)) begin
      value <= value - ONE;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/wm_program_controller.sv
// rtl/wm_program_controller.sv - washing-machine program sequencer with modes, pause, cancel and faults
module wm_program_controller
  import wm_pkg::*;
#(
  parameter int TIMER_W     = 16,
  parameter int RINSE_W     = 2,
  parameter int WASH_TICKS  = 600,
  parameter int RINSE_TICKS = 300,
  parameter int SPIN_TICKS  = 240,
  parameter int FILL_TMO    = 120,
  parameter int DRAIN_TMO   = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic               cancel,
  input  logic               pause,
  input  logic               door_close,
  input  logic               filled,
  input  logic               drained,
  input  logic               detergent_added,
  input  logic [1:0]         mode,
  input  logic [RINSE_W-1:0] num_rinses,
  output logic               door_lock,
  output logic               motor_on,
  output logic               motor_fast,
  output logic               fill_valve_on,
  output logic               drain_valve_on,
  output logic               soap_phase,
  output logic               rinse_phase,
  output logic               paused,
  output logic               done,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic [RINSE_W-1:0] rinse_left,
  output logic [TIMER_W-1:0] time_left,
  output logic [3:0]         state_o
);

  localparam logic [TIMER_W-1:0] FILL_T       = TIMER_W'(FILL_TMO);
  localparam logic [TIMER_W-1:0] DRAIN_T      = TIMER_W'(DRAIN_TMO);
  localparam logic [TIMER_W-1:0] WASH_T       = TIMER_W'(WASH_TICKS);
  localparam logic [TIMER_W-1:0] WASH_QUICK_T = TIMER_W'(WASH_TICKS / 2);
  localparam logic [TIMER_W-1:0] WASH_HEAVY_T = TIMER_W'(WASH_TICKS * 2);
  localparam logic [TIMER_W-1:0] RINSE_T      = TIMER_W'(RINSE_TICKS);
  localparam logic [TIMER_W-1:0] SPIN_T       = TIMER_W'(SPIN_TICKS);
  localparam logic [RINSE_W-1:0] ONE_R        = RINSE_W'(1);

  wm_state_e          state, state_n;
  logic [1:0]         mode_q, mode_n;
  logic               rinse_pass, rinse_pass_n;
  logic [RINSE_W-1:0] rinse_left_n;
  logic [1:0]         fault_code_n;
  logic               paused_q, paused_n;
  logic               timer_load, timer_hold, timer_zero;
  logic [TIMER_W-1:0] timer_load_value;

  wm_phase_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_load_value),
    .tick       (tick),
    .hold       (timer_hold),
    .value      (time_left),
    .zero       (timer_zero)
  );

  // Sequencer state and the per-run context latched alongside it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      mode_q     <= MODE_NORMAL;
      rinse_pass <= 1'b0;
      rinse_left <= '0;
      fault_code <= FC_NONE;
      paused_q   <= 1'b0;
    end else begin
      state      <= state_n;
      mode_q     <= mode_n;
      rinse_pass <= rinse_pass_n;
      rinse_left <= rinse_left_n;
      fault_code <= fault_code_n;
      paused_q   <= paused_n;
    end
  end

  // Next-state: cancel > door fault > pause hold > timeout > sensor.
  always_comb begin
    state_n      = state;
    mode_n       = mode_q;
    rinse_pass_n = rinse_pass;
    rinse_left_n = rinse_left;
    fault_code_n = fault_code;
    paused_n     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && door_close && !cancel) begin
          state_n = ST_FILL;
          mode_n  = mode;
          if (mode == MODE_RINSE) begin
            // Rinse-only runs at least one rinse, and this first fill already is one.
            rinse_pass_n = 1'b1;
            rinse_left_n = (num_rinses == '0) ? '0 : num_rinses - ONE_R;
          end else begin
            rinse_pass_n = 1'b0;
            rinse_left_n = num_rinses;
          end
        end
      end
      ST_FILL, ST_SOAP, ST_WASH, ST_DRAIN, ST_SPIN: begin
        if (cancel) begin
          state_n = ST_ABORT_DRAIN;
        end else if (!door_close) begin
          state_n      = ST_FAULT;
          fault_code_n = FC_DOOR;
        end else if (pause) begin
          paused_n = 1'b1;
        end else begin
          case (state)
            ST_FILL: begin
              if (timer_zero) begin
                state_n      = ST_FAULT;
                fault_code_n = FC_FILL_TMO;
              end else if (filled) begin
                state_n = rinse_pass ? ST_WASH : ST_SOAP;
              end
            end
            ST_SOAP: if (detergent_added) state_n = ST_WASH;
            ST_WASH: if (timer_zero) state_n = ST_DRAIN;
            ST_DRAIN: begin
              if (timer_zero) begin
                state_n      = ST_FAULT;
                fault_code_n = FC_DRAIN_TMO;
              end else if (drained) begin
                if (rinse_left != '0) begin
                  state_n      = ST_FILL;
                  rinse_pass_n = 1'b1;
                  rinse_left_n = rinse_left - ONE_R;
                end else begin
                  state_n = ST_SPIN;
                end
              end
            end
            ST_SPIN: if (timer_zero) state_n = ST_DONE;
            default: ;
          endcase
        end
      end
      ST_ABORT_DRAIN: begin
        if (!door_close) begin
          state_n      = ST_FAULT;
          fault_code_n = FC_DOOR;
        end else if (timer_zero) begin
          state_n      = ST_FAULT;
          fault_code_n = FC_DRAIN_TMO;
        end else if (drained) begin
          state_n = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (cancel) begin
          state_n      = ST_ABORT_DRAIN;
          fault_code_n = FC_NONE;
        end
      end
      ST_DONE: if (!door_close || cancel) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    // Back in IDLE nothing of the previous run remains visible.
    if ((state_n == ST_IDLE) && (state != ST_IDLE)) begin
      rinse_pass_n = 1'b0;
      rinse_left_n = '0;
    end
  end

  // Phase timer reloads on every state entry; duration is chosen by the state being entered.
  always_comb begin
    timer_load       = (state_n != state);
    timer_hold       = pause && is_active(state);
    timer_load_value = '0;
    case (state_n)
      ST_FILL:                  timer_load_value = FILL_T;
      ST_DRAIN, ST_ABORT_DRAIN: timer_load_value = DRAIN_T;
      ST_SPIN:                  timer_load_value = SPIN_T;
      ST_WASH: begin
        if (rinse_pass_n) begin
          timer_load_value = RINSE_T;
        end else begin
          case (mode_q)
            MODE_QUICK: timer_load_value = WASH_QUICK_T;
            MODE_HEAVY: timer_load_value = WASH_HEAVY_T;
            default:    timer_load_value = WASH_T;
          endcase
        end
      end
      default: timer_load_value = '0;
    endcase
  end

  // Moore outputs from registered state; a registered pause masks the actuators.
  always_comb begin
    door_lock      = 1'b0;
    motor_on       = 1'b0;
    motor_fast     = 1'b0;
    fill_valve_on  = 1'b0;
    drain_valve_on = 1'b0;
    soap_phase     = 1'b0;
    rinse_phase    = 1'b0;
    done           = 1'b0;
    fault          = 1'b0;
    case (state)
      ST_FILL: begin
        door_lock     = 1'b1;
        fill_valve_on = !paused_q;
        soap_phase    = !rinse_pass;
        rinse_phase   = rinse_pass;
      end
      ST_SOAP: begin
        door_lock  = 1'b1;
        soap_phase = 1'b1;
      end
      ST_WASH: begin
        door_lock   = 1'b1;
        motor_on    = !paused_q;
        soap_phase  = !rinse_pass;
        rinse_phase = rinse_pass;
      end
      ST_DRAIN: begin
        door_lock      = 1'b1;
        drain_valve_on = !paused_q;
        soap_phase     = !rinse_pass;
        rinse_phase    = rinse_pass;
      end
      ST_SPIN: begin
        door_lock      = 1'b1;
        motor_on       = !paused_q;
        motor_fast     = !paused_q;
        drain_valve_on = !paused_q;
      end
      ST_DONE: done = 1'b1;
      ST_ABORT_DRAIN: begin
        door_lock      = 1'b1;
        drain_valve_on = 1'b1;
      end
      ST_FAULT: begin
        door_lock = 1'b1;
        fault     = 1'b1;
      end
      default: ;
    endcase
  end

  assign paused  = paused_q;
  assign state_o = state;

endmodule

// File: tb/tb_wm_program_controller.sv
// tb/tb_wm_program_controller.sv - scoreboard bench for the washer sequencer
module tb_wm_program_controller;

  localparam logic [3:0] S_IDLE = 4'd0, S_FILL = 4'd1, S_SOAP = 4'd2, S_WASH = 4'd3,
                         S_DRAIN = 4'd4, S_SPIN = 4'd5, S_DONE = 4'd6, S_ABORT = 4'd7,
                         S_FAULT = 4'd8;

  typedef struct packed {
    logic [3:0]  st;
    logic        lock, mot, fast, fillv, drainv, soap, rinse, dn, flt;
    logic [1:0]  code;
    logic [1:0]  rl;
    logic [15:0] tl;
  } snap_t;

  logic clk = 1'b0, reset = 1'b0, tick = 1'b0;
  logic start = 1'b0, cancel = 1'b0, pause = 1'b0, door_close = 1'b1;
  logic filled = 1'b0, drained = 1'b0, detergent_added = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [1:0] num_rinses = 2'd0;
  logic door_lock, motor_on, motor_fast, fill_valve_on, drain_valve_on;
  logic soap_phase, rinse_phase, paused, done, fault;
  logic [1:0] fault_code, rinse_left;
  logic [15:0] time_left;
  logic [3:0] state_o;

  logic fill_ok = 1'b1, drain_ok = 1'b1;
  int n_tests = 0, n_fail = 0;
  snap_t exp_q[$];

  wm_program_controller dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .cancel(cancel), .pause(pause),
    .door_close(door_close), .filled(filled), .drained(drained),
    .detergent_added(detergent_added), .mode(mode), .num_rinses(num_rinses),
    .door_lock(door_lock), .motor_on(motor_on), .motor_fast(motor_fast),
    .fill_valve_on(fill_valve_on), .drain_valve_on(drain_valve_on),
    .soap_phase(soap_phase), .rinse_phase(rinse_phase), .paused(paused), .done(done),
    .fault(fault), .fault_code(fault_code), .rinse_left(rinse_left),
    .time_left(time_left), .state_o(state_o)
  );

  initial forever #5 clk = ~clk;

  // one-clk tick every second clock, changed just after the rising edge
  initial forever begin
    @(posedge clk);
    #1 tick = ~tick;
  end

  function automatic snap_t mk(logic [3:0] st, logic lock, logic mot, logic fast, logic fillv,
                               logic drainv, logic soap, logic rinse, logic dn, logic flt,
                               logic [1:0] code, logic [1:0] rl, logic [15:0] tl);
    snap_t s;
    s = '{st, lock, mot, fast, fillv, drainv, soap, rinse, dn, flt, code, rl, tl};
    return s;
  endfunction

  function automatic snap_t e_idle();
    return mk(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'd0);
  endfunction
  function automatic snap_t e_fill(logic [1:0] rl, logic rp);
    return mk(S_FILL, 1, 0, 0, 1, 0, !rp, rp, 0, 0, 2'd0, rl, 16'd120);
  endfunction
  function automatic snap_t e_soap(logic [1:0] rl);
    return mk(S_SOAP, 1, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, rl, 16'd0);
  endfunction
  function automatic snap_t e_wash(logic [1:0] rl, logic rp, logic [15:0] tl);
    return mk(S_WASH, 1, 1, 0, 0, 0, !rp, rp, 0, 0, 2'd0, rl, tl);
  endfunction
  function automatic snap_t e_drain(logic [1:0] rl, logic rp);
    return mk(S_DRAIN, 1, 0, 0, 0, 1, !rp, rp, 0, 0, 2'd0, rl, 16'd120);
  endfunction
  function automatic snap_t e_spin();
    return mk(S_SPIN, 1, 1, 1, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 16'd240);
  endfunction
  function automatic snap_t e_done();
    return mk(S_DONE, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 16'd0);
  endfunction
  function automatic snap_t e_abort(logic [1:0] rl);
    return mk(S_ABORT, 1, 0, 0, 0, 1, 0, 0, 0, 0, 2'd0, rl, 16'd120);
  endfunction
  function automatic snap_t e_fault(logic [1:0] rl, logic [1:0] code);
    return mk(S_FAULT, 1, 0, 0, 0, 0, 0, 0, 0, 1, code, rl, 16'd0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string nm);
    int n = 0;
    @(negedge clk);
    while (state_o != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {28'd0, state_o}, {28'd0, s});
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [1:0] nr);
    mode = m;
    num_rinses = nr;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_cancel();
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
  endtask

  // sensor model: filled/drained answer 3 ticks after the valve opens; detergent in SOAP
  initial begin
    int fcnt = 0, dcnt = 0;
    forever begin
      @(negedge clk);
      if (!fill_valve_on) fcnt = 0; else if (tick && fcnt < 7) fcnt++;
      if (!drain_valve_on) dcnt = 0; else if (tick && dcnt < 7) dcnt++;
      filled = fill_ok && fill_valve_on && (fcnt >= 3);
      drained = drain_ok && drain_valve_on && (dcnt >= 3);
      detergent_added = soap_phase && door_lock && !fill_valve_on && !motor_on &&
                        !drain_valve_on && !paused;
    end
  end

  // monitor: every state entry is compared against the next expected snapshot
  initial begin
    logic [3:0] prev = S_IDLE;
    snap_t act, e;
    forever begin
      @(negedge clk);
      if (state_o !== prev) begin
        act = mk(state_o, door_lock, motor_on, motor_fast, fill_valve_on, drain_valve_on,
                 soap_phase, rinse_phase, done, fault, fault_code, rinse_left, time_left);
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_entry got=%h", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL state_entry got=%h want=%h", act, e);
          end
        end
        prev = state_o;
      end
    end
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {door_lock, motor_on, motor_fast, fill_valve_on, drain_valve_on,
        soap_phase, rinse_phase, paused, done, fault, fault_code, rinse_left, state_o,
        time_left[11:0]}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1: normal wash, two rinses
    exp_q.push_back(e_fill(2, 0)); exp_q.push_back(e_soap(2));
    exp_q.push_back(e_wash(2, 0, 16'd600)); exp_q.push_back(e_drain(2, 0));
    exp_q.push_back(e_fill(1, 1)); exp_q.push_back(e_wash(1, 1, 16'd300));
    exp_q.push_back(e_drain(1, 1)); exp_q.push_back(e_fill(0, 1));
    exp_q.push_back(e_wash(0, 1, 16'd300)); exp_q.push_back(e_drain(0, 1));
    exp_q.push_back(e_spin()); exp_q.push_back(e_done());
    pulse_start(2'd0, 2'd2);
    wait_state(S_DONE, 6000, "t1_reach_done");
    chk("t1_done_unlocked", {31'd0, door_lock}, 32'd0);
    exp_q.push_back(e_idle());
    door_close = 1'b0;
    wait_state(S_IDLE, 10, "t1_door_open_idle");
    door_close = 1'b1;
    @(negedge clk);

    // 2a: quick wash; mode/rinse inputs changed mid-run are ignored
    exp_q.push_back(e_fill(0, 0)); exp_q.push_back(e_soap(0));
    exp_q.push_back(e_wash(0, 0, 16'd300)); exp_q.push_back(e_abort(0));
    exp_q.push_back(e_idle());
    pulse_start(2'd1, 2'd0);
    mode = 2'd2;
    num_rinses = 2'd3;
    wait_state(S_WASH, 200, "t2_quick_wash");
    pulse_cancel();
    wait_state(S_IDLE, 200, "t2_quick_abort_idle");

    // 2b: heavy wash
    exp_q.push_back(e_fill(0, 0)); exp_q.push_back(e_soap(0));
    exp_q.push_back(e_wash(0, 0, 16'd1200)); exp_q.push_back(e_abort(0));
    exp_q.push_back(e_idle());
    pulse_start(2'd2, 2'd0);
    wait_state(S_WASH, 200, "t2_heavy_wash");
    pulse_cancel();
    wait_state(S_IDLE, 200, "t2_heavy_abort_idle");

    // 2c: rinse-only with zero rinses still runs exactly one rinse, no SOAP
    exp_q.push_back(e_fill(0, 1)); exp_q.push_back(e_wash(0, 1, 16'd300));
    exp_q.push_back(e_drain(0, 1)); exp_q.push_back(e_spin()); exp_q.push_back(e_done());
    pulse_start(2'd3, 2'd0);
    wait_state(S_DONE, 2000, "t2_rinse_only_done");
    exp_q.push_back(e_idle());
    door_close = 1'b0;
    wait_state(S_IDLE, 10, "t2_rinse_only_idle");
    door_close = 1'b1;
    @(negedge clk);

    // 3: fill timeout after exactly 120 ticks, then cancel-with-drain
    fill_ok = 1'b0;
    exp_q.push_back(e_fill(1, 0)); exp_q.push_back(e_fault(1, 2'd1));
    exp_q.push_back(e_abort(1)); exp_q.push_back(e_idle());
    pulse_start(2'd0, 2'd1);
    k = 0;
    for (int i = 0; i < 1000 && state_o == S_FILL; i++) begin
      if (tick) k++;
      @(negedge clk);
    end
    chk("t3_fill_tmo_ticks", k, 32'd120);
    chk("t3_fault_state", {28'd0, state_o}, {28'd0, S_FAULT});
    fill_ok = 1'b1;
    pulse_cancel();
    wait_state(S_IDLE, 200, "t3_abort_idle");

    // 4: pause mid-wash freezes the timer and stops the motor
    exp_q.push_back(e_fill(0, 0)); exp_q.push_back(e_soap(0));
    exp_q.push_back(e_wash(0, 0, 16'd600)); exp_q.push_back(e_abort(0));
    exp_q.push_back(e_idle());
    pulse_start(2'd0, 2'd0);
    wait_state(S_WASH, 200, "t4_wash");
    k = 0;
    for (int i = 0; i < 200; i++) begin
      if (tick) k++;
      if (k == 20) break;
      @(negedge clk);
    end
    @(negedge clk);
    pause = 1'b1;
    repeat (2) @(negedge clk);
    chk("t4_paused_flag", {31'd0, paused}, 32'd1);
    chk("t4_motor_off", {31'd0, motor_on}, 32'd0);
    chk("t4_door_locked", {31'd0, door_lock}, 32'd1);
    chk("t4_time_at_pause", {16'd0, time_left}, 32'd580);
    repeat (100) @(negedge clk);
    chk("t4_time_frozen", {16'd0, time_left}, 32'd580);
    chk("t4_still_wash", {28'd0, state_o}, {28'd0, S_WASH});
    pause = 1'b0;
    @(negedge clk);
    chk("t4_time_resume", {16'd0, time_left}, 32'd580);
    @(negedge clk);
    chk("t4_motor_back", {30'd0, motor_on, paused}, 32'd2);
    pulse_cancel();
    wait_state(S_IDLE, 200, "t4_abort_idle");

    // 5: door opened in SPIN -> door fault; cancel+start in IDLE stays IDLE
    exp_q.push_back(e_fill(0, 0)); exp_q.push_back(e_soap(0));
    exp_q.push_back(e_wash(0, 0, 16'd300)); exp_q.push_back(e_drain(0, 0));
    exp_q.push_back(e_spin()); exp_q.push_back(e_fault(0, 2'd3));
    exp_q.push_back(e_abort(0)); exp_q.push_back(e_idle());
    pulse_start(2'd1, 2'd0);
    wait_state(S_SPIN, 1500, "t5_spin");
    door_close = 1'b0;
    wait_state(S_FAULT, 10, "t5_door_fault");
    door_close = 1'b1;
    @(negedge clk);
    pulse_cancel();
    wait_state(S_IDLE, 200, "t5_abort_idle");
    start = 1'b1;
    cancel = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_cancel_beats_start", {28'd0, state_o}, {28'd0, S_IDLE});
    start = 1'b0;
    cancel = 1'b0;
    @(negedge clk);

    // 6: asynchronous reset in DRAIN
    drain_ok = 1'b0;
    exp_q.push_back(e_fill(0, 0)); exp_q.push_back(e_soap(0));
    exp_q.push_back(e_wash(0, 0, 16'd300)); exp_q.push_back(e_drain(0, 0));
    exp_q.push_back(e_idle());
    pulse_start(2'd1, 2'd0);
    wait_state(S_DRAIN, 1500, "t6_drain");
    repeat (5) @(negedge clk);
    #3 reset = 1'b0;
    #1;
    chk("t6_reset_outputs", {door_lock, motor_on, motor_fast, fill_valve_on, drain_valve_on,
        soap_phase, rinse_phase, paused, done, fault, fault_code, rinse_left, state_o,
        time_left[11:0]}, 32'd0);
    chk("t6_reset_timer_hi", {28'd0, time_left[15:12]}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drain_ok = 1'b1;

    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
